i2s_rx_param: RTL and testbench
===============================

I2S_RX_PARAM -- requirements
Module: i2s_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, output sample width in bits (legal 8..32).
REQ-002 SHALL have parameter MODE, default 0, word framing: 0 = I2S (one-bit delay after LRCLK change), 1 = left-justified.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for SCK/LRCLK/SDATA (legal 2..3).
REQ-004 SHALL have the following ports: one clock; reset is synchronous and active-high.
  clk12m  in  1  system clock; all logic on its rising edge.
  reset  in  1  synchronous active-high reset.
  SCK  in  1  asynchronous I2S bit clock.
  LRCLK  in  1  asynchronous word select: 0 = left, 1 = right.
  SDATA  in  1  asynchronous serial data, MSB first.
  out_ready  in  1  consumer accepts the current pair.
  ovr_clr  in  1  clears the overrun flag.
  sample_l  out  DATA_W  left sample, MSB-aligned.
  sample_r  out  DATA_W  right sample, MSB-aligned.
  out_valid  out  1  stereo pair available.
  overrun  out  1  sticky; a pair was overwritten before it was accepted.

Function
REQ-005 SHALL synchronise SCK, LRCLK and SDATA through SYNC_STAGES flops; SCK high and low phases are each at least 2 clk12m periods.
REQ-006 SHALL treat a synchronised SCK 0->1 transition as a bit event, sampling synchronised SDATA and LRCLK in that same cycle.
REQ-007 SHALL define a word-select change as a bit event whose sampled LRCLK differs from the LRCLK value held at the previous bit event.
REQ-008 SHALL use FSM states HUNT, SHIFT. HUNT is entered after reset. HUNT goes to SHIFT on the first word-select change, and bits seen in HUNT are discarded.
REQ-009 MODE 0: the bit captured at a word-select change SHALL be the last bit of the closing word; the next bit event SHALL be the MSB of the new word.
REQ-010 MODE 1: a word-select change SHALL close the previous word without that bit; that bit SHALL be the MSB of the new word.
REQ-011 SHALL count bits per word, saturating at DATA_W; bits beyond DATA_W SHALL be ignored.
REQ-012 A closing word with count n < DATA_W SHALL be left-aligned with zeros in the low DATA_W-n bits; a word with n = 0 SHALL be 0.
REQ-013 A closed left word SHALL be held as pending-left; a closed right word with pending-left set SHALL form a pair; a right word without pending-left SHALL be discarded.
REQ-014 SHALL load sample_l and sample_r and set out_valid on the clk12m edge after the bit event that closes the right word. Latency SHALL be at most SYNC_STAGES+2 cycles from the SCK pin edge.
REQ-015 out_valid SHALL stay high with sample_l and sample_r stable until a cycle with out_valid && out_ready; out_valid SHALL then clear on the next edge.
REQ-016 If a new pair forms while out_valid=1 and out_ready=0, the block SHALL overwrite the outputs, keep out_valid=1 and set overrun.
REQ-017 If a pair forms in the same cycle as an out_valid && out_ready handshake, the block SHALL load the new pair, keep out_valid=1 and not set overrun.
REQ-018 overrun SHALL clear on ovr_clr unless a new overrun occurs in the same cycle; set wins.

Reset
REQ-019 On reset: sample_l=0, sample_r=0, out_valid=0, overrun=0, FSM=HUNT, counters, shift register, pending-left and LRCLK history cleared. Synchroniser flops SHALL reset to 0.
REQ-020 Reset asserted mid-word SHALL discard partial data; the first pair after reset SHALL need a full left word followed by a right word.

Structure
REQ-021 SHALL place the MODE encodings and the FSM state encodings in the shared package i2s_pkg.
REQ-022 SHALL implement the synchroniser and SCK edge detector as sub-module i2s_pin_sync, instantiated once.

Verification
REQ-023 Test: MODE 0, DATA_W=16, 8-bit slots, left 0xED, right 0x99, LRCLK changing with the LSB, out_ready=1 -> pairs sample_l=0xED00, sample_r=0x9900, one out_valid pulse per frame.
REQ-024 Test: MODE 1, DATA_W=24, 32-bit slots, left 0x123456FF, right 0xABCDEF00 -> sample_l=0x123456, sample_r=0xABCDEF (extra bits ignored).
REQ-025 Test: out_ready=0 for two frames -> overrun=1, outputs hold the second pair. Then ovr_clr pulse -> overrun=0.
REQ-026 Test: out_ready high exactly on the cycle a new pair forms -> out_valid stays 1, overrun stays 0, new data is presented.
REQ-027 Test: reset mid-left-word, then a right word only -> no out_valid; the next full left+right frame -> exactly one valid pair.
REQ-028 Test: slot of 0 bits (back-to-back LRCLK toggles) -> sample=0x0000 with no lockup, and normal pairs resume afterwards.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Purpose  : Shared framing-mode and receiver FSM encodings for the I2S slice.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Word framing selected by the MODE parameter
    localparam int c_MODE_I2S = 0;
    localparam int c_MODE_LJ  = 1;

    // Receiver FSM states
    localparam logic [0:0] c_ST_HUNT  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2s_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pin_sync
// Purpose  : Synchronises SCK/LRCLK/SDATA and flags synchronised SCK rises.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_sck_rise,
    output logic o_lrclk,
    output logic o_sdata
);

    // All three pins share one chain so SDATA/LRCLK stay aligned with SCK
    logic [2:0] r_sync [SYNC_STAGES];
    logic       r_sck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b000;
            end
            r_sck_d <= 1'b0;
        end else begin
            r_sync[0] <= {i_sck, i_lrclk, i_sdata};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sck_d <= r_sync[SYNC_STAGES-1][2];
        end
    end

    assign o_sck_rise = r_sync[SYNC_STAGES-1][2] & ~r_sck_d;
    assign o_lrclk    = r_sync[SYNC_STAGES-1][1];
    assign o_sdata    = r_sync[SYNC_STAGES-1][0];

endmodule
`default_nettype wire

// File: rtl/i2s_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_param
// Purpose  : Parameterised I2S / left-justified stereo receiver with a
//            valid/ready pair output and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_param
    import i2s_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk12m,
    input  logic              reset,
    input  logic              SCK,
    input  logic              LRCLK,
    input  logic              SDATA,
    input  logic              out_ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              out_valid,
    output logic              overrun
);

    localparam int              c_CW   = $clog2(DATA_W + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DATA_W);
    localparam bit              c_LJ   = (MODE == c_MODE_LJ);

    logic              w_bit_ev;
    logic              w_lr;
    logic              w_sd;
    logic [0:0]        r_state;
    logic              r_ws_prev;
    logic [DATA_W-1:0] r_shift;
    logic [c_CW-1:0]   r_cnt;
    logic              r_pend_l;
    logic [DATA_W-1:0] r_pend_data;

    i2s_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .clk       (clk12m),
        .rst       (reset),
        .i_sck     (SCK),
        .i_lrclk   (LRCLK),
        .i_sdata   (SDATA),
        .o_sck_rise(w_bit_ev),
        .o_lrclk   (w_lr),
        .o_sdata   (w_sd)
    );

    logic              w_ws_chg;
    logic              w_room;
    logic [DATA_W-1:0] w_msb_vec;
    logic [DATA_W-1:0] w_ins;
    logic [c_CW-1:0]   w_cnt_inc;
    logic [DATA_W-1:0] w_close;
    logic              w_closing;
    logic              w_close_left;
    logic              w_pair;

    // Bits land MSB-first at their final position, so short words come out
    // left-aligned and zero-filled without a final shift.
    assign w_ws_chg     = w_bit_ev && (w_lr != r_ws_prev);
    assign w_room       = (r_cnt != c_FULL);
    assign w_msb_vec    = {w_sd, {(DATA_W-1){1'b0}}};
    assign w_ins        = w_room ? (r_shift | (w_msb_vec >> r_cnt)) : r_shift;
    assign w_cnt_inc    = w_room ? (r_cnt + c_CW'(1)) : r_cnt;
    assign w_close      = c_LJ ? r_shift : w_ins;
    assign w_closing    = w_ws_chg && (r_state == c_ST_SHIFT);
    // The closing word belongs to the channel held before this change
    assign w_close_left = w_closing && !r_ws_prev;
    assign w_pair       = w_closing && r_ws_prev && r_pend_l;

    always_ff @(posedge clk12m) begin
        if (reset) begin
            r_state     <= c_ST_HUNT;
            r_ws_prev   <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend_l    <= 1'b0;
            r_pend_data <= '0;
            sample_l    <= '0;
            sample_r    <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_bit_ev) begin
                r_ws_prev <= w_lr;
                if (w_ws_chg) begin
                    r_state <= c_ST_SHIFT;
                    if (c_LJ) begin
                        r_shift <= w_msb_vec;
                        r_cnt   <= c_CW'(1);
                    end else begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end else begin
                    r_shift <= w_ins;
                    r_cnt   <= w_cnt_inc;
                end
            end

            if (w_close_left) begin
                r_pend_l    <= 1'b1;
                r_pend_data <= w_close;
            end else if (w_closing && r_ws_prev) begin
                r_pend_l <= 1'b0;
            end

            if (w_pair) begin
                sample_l  <= r_pend_data;
                sample_r  <= w_close;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A fresh overrun takes priority over a clear in the same cycle
            if (w_pair && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2s_rx_param
// Purpose  : Directed self-checking bench for i2s_rx_param (I2S and LJ modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_param;

    logic clk12m = 1'b0;
    always #5 clk12m = ~clk12m;

    logic        reset;
    logic        sck;
    logic        lrclk;
    logic        sdata;
    logic        out_ready;
    logic        ovr_clr;
    logic [15:0] l0;
    logic [15:0] r0;
    logic        v0;
    logic        o0;
    logic [23:0] l1;
    logic [23:0] r1;
    logic        v1;
    logic        o1;

    int n_assert = 0;
    int n_fail   = 0;
    int vcnt0    = 0;
    int vcnt1    = 0;
    int base;

    i2s_rx_param #(.DATA_W(16), .MODE(0), .SYNC_STAGES(2)) u_dut0 (
        .clk12m(clk12m), .reset(reset), .SCK(sck), .LRCLK(lrclk), .SDATA(sdata),
        .out_ready(out_ready), .ovr_clr(ovr_clr),
        .sample_l(l0), .sample_r(r0), .out_valid(v0), .overrun(o0)
    );

    i2s_rx_param #(.DATA_W(24), .MODE(1), .SYNC_STAGES(3)) u_dut1 (
        .clk12m(clk12m), .reset(reset), .SCK(sck), .LRCLK(lrclk), .SDATA(sdata),
        .out_ready(out_ready), .ovr_clr(ovr_clr),
        .sample_l(l1), .sample_r(r1), .out_valid(v1), .overrun(o1)
    );

    // Cycles with out_valid high; with out_ready=1 each pair gives one cycle
    always @(negedge clk12m) begin
        if (v0) vcnt0++;
        if (v1) vcnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk12m);
    endtask

    // One bit: 3 cycles low with data set up, 3 cycles high; optional
    // out_ready pulse aligned with the cycle a pair forms in the MODE 0 DUT.
    task automatic send_bit(input logic lr, input logic d, input bit pulse);
        sck   = 1'b0;
        lrclk = lr;
        sdata = d;
        tick(3);
        sck = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk12m);
            if (pulse && k == 1) out_ready = 1'b1;
            else if (pulse && k == 2) out_ready = 1'b0;
        end
    endtask

    task automatic word_m0(input logic [31:0] w, input int bits, input logic ch, input bit pulse);
        for (int i = bits - 1; i >= 0; i--) begin
            send_bit((i == 0) ? ~ch : ch, w[i], pulse && (i == 0));
        end
    endtask

    task automatic frame_m0(input logic [31:0] lw, input logic [31:0] rw, input bit pulse);
        word_m0(lw, 8, 1'b0, 1'b0);
        word_m0(rw, 8, 1'b1, pulse);
    endtask

    task automatic frame_m1(input logic [31:0] lw, input logic [31:0] rw);
        for (int i = 31; i >= 0; i--) send_bit(1'b0, lw[i], 1'b0);
        for (int i = 31; i >= 0; i--) send_bit(1'b1, rw[i], 1'b0);
    endtask

    initial begin
        reset = 1'b1; sck = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        out_ready = 1'b1; ovr_clr = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(2);
        chk("rst_l0", 32'(l0), 32'h0);
        chk("rst_r0", 32'(r0), 32'h0);
        chk("rst_v0", 32'(v0), 32'h0);
        chk("rst_o0", 32'(o0), 32'h0);
        chk("rst_v1", 32'(v1), 32'h0);
        chk("rst_o1", 32'(o1), 32'h0);

        // I2S 8-bit slots into 16-bit samples, one preamble frame to lock
        base = vcnt0;
        frame_m0(32'h00, 32'h00, 1'b0);
        chk("m0_preamble_no_pair", 32'(vcnt0 - base), 32'd0);
        for (int f = 0; f < 3; f++) frame_m0(32'hED, 32'h99, 1'b0);
        tick(6);
        chk("m0_pair_count", 32'(vcnt0 - base), 32'd3);
        chk("m0_sample_l", 32'(l0), 32'hED00);
        chk("m0_sample_r", 32'(r0), 32'h9900);
        chk("m0_valid_consumed", 32'(v0), 32'h0);

        // Two unaccepted pairs -> overrun, second pair held
        out_ready = 1'b0;
        frame_m0(32'hA1, 32'hB2, 1'b0);
        tick(6);
        chk("ovr_first_valid", 32'(v0), 32'h1);
        chk("ovr_first_noovr", 32'(o0), 32'h0);
        frame_m0(32'hC3, 32'hD4, 1'b0);
        tick(6);
        chk("ovr_valid", 32'(v0), 32'h1);
        chk("ovr_flag", 32'(o0), 32'h1);
        chk("ovr_sample_l", 32'(l0), 32'hC300);
        chk("ovr_sample_r", 32'(r0), 32'hD400);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        tick(1);
        chk("ovr_cleared", 32'(o0), 32'h0);
        chk("ovr_valid_kept", 32'(v0), 32'h1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(1);
        chk("ovr_handshake_clears", 32'(v0), 32'h0);

        // Handshake in the very cycle a new pair forms
        frame_m0(32'h11, 32'h22, 1'b0);
        tick(6);
        chk("hs_first_valid", 32'(v0), 32'h1);
        chk("hs_first_l", 32'(l0), 32'h1100);
        frame_m0(32'h33, 32'h44, 1'b1);
        tick(6);
        chk("hs_valid_kept", 32'(v0), 32'h1);
        chk("hs_no_overrun", 32'(o0), 32'h0);
        chk("hs_new_l", 32'(l0), 32'h3300);
        chk("hs_new_r", 32'(r0), 32'h4400);
        out_ready = 1'b1;
        tick(2);
        chk("hs_consumed", 32'(v0), 32'h0);

        // Back-to-back LRCLK toggles -> one-bit (zero data) words, then resume
        base = vcnt0;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        tick(6);
        chk("toggle_pairs", 32'(vcnt0 - base), 32'd2);
        chk("toggle_l", 32'(l0), 32'h0);
        chk("toggle_r", 32'(r0), 32'h0);
        frame_m0(32'hED, 32'h99, 1'b0);
        tick(6);
        chk("resume_pairs", 32'(vcnt0 - base), 32'd3);
        chk("resume_l", 32'(l0), 32'hED00);
        chk("resume_r", 32'(r0), 32'h9900);

        // Reset mid-left-word; a lone right word must not form a pair
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("midrst_l", 32'(l0), 32'h0);
        chk("midrst_v", 32'(v0), 32'h0);
        base = vcnt0;
        word_m0(32'h5A, 8, 1'b1, 1'b0);
        tick(6);
        chk("midrst_right_only", 32'(vcnt0 - base), 32'd0);
        frame_m0(32'h5A, 32'hA5, 1'b0);
        tick(6);
        chk("midrst_one_pair", 32'(vcnt0 - base), 32'd1);
        chk("midrst_l_data", 32'(l0), 32'h5A00);
        chk("midrst_r_data", 32'(r0), 32'hA500);

        // Left-justified, 32-bit slots into 24-bit samples
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        base = vcnt1;
        frame_m1(32'h0, 32'h0);
        frame_m1(32'h123456FF, 32'hABCDEF00);
        frame_m1(32'h123456FF, 32'hABCDEF00);
        tick(8);
        chk("lj_pair_count", 32'(vcnt1 - base), 32'd1);
        chk("lj_sample_l", 32'(l1), 32'h123456);
        chk("lj_sample_r", 32'(r1), 32'hABCDEF);
        chk("lj_no_overrun", 32'(o1), 32'h0);
        chk("lj_consumed", 32'(v1), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
